// File: rtl/can_mc_pkg.sv
// can_mc_pkg
// Shared types and constants for the MC-interface arbiter slice.
//   state_t      : arbiter FSM states (IDLE, WAIT, GAP)
//   ADDR_W/DATA_W: MC register address / data widths
//   REQ_HOST/REQ_ENGINE : requester indices (bit positions in i_req)
//   onehot2()    : requester index -> one-hot 2-bit vector
package can_mc_pkg;

   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 32;
   localparam int NUM_REQ = 2;

   localparam logic REQ_HOST   = 1'b0;
   localparam logic REQ_ENGINE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic logic [1:0] onehot2(input logic idx);
      return (idx == REQ_ENGINE) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/can_rr_arb2.sv
// can_rr_arb2
// Combinational two-way round-robin pick.
//   req   : request vector (bit0 host, bit1 engine)
//   ptr   : requester that wins a tie
//   valid : at least one request present
//   idx   : index of the winning requester (meaningful when valid)
module can_rr_arb2
   import can_mc_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       valid,
   output logic       idx
);

   always_comb begin
      valid = |req;
      idx   = ptr;
      // Pointed requester keeps priority; fall over only when it is idle.
      if (!req[ptr]) begin
         idx = ~ptr;
      end
   end

endmodule

// File: rtl/can_mc_arbiter.sv
// can_mc_arbiter
// Arbitrates the host and the internal engine onto a single MC register
// interface, one transaction at a time, with a per-transaction timeout.
//
// Ports
//   i_sys_clk, i_reset            : clock, async active-high reset
//   i_req[1:0], i_rnw[1:0]        : per-requester request level and read/write
//   i_addr0/1, i_wdata0/1         : per-requester address and write data
//   o_gnt, o_done, o_err          : one-hot grant, completion pulse, error flag
//   o_rdata, o_timeout            : read data (valid with o_done), timeout pulse
//   o_cs, o_r_neg_w, o_addr,
//   o_wdata                       : MC interface command
//   i_ack, i_error, i_rdata       : MC interface response
//
// state | meaning
// IDLE  | no transaction; pick a winner and latch its command when any i_req
// WAIT  | o_cs high, command stable; wait for i_ack or timeout terminal count
// GAP   | one dead cycle with o_cs low so the MC interface re-decodes
module can_mc_arbiter
   import can_mc_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              i_sys_clk,
   input  logic              i_reset,
   input  logic [1:0]        i_req,
   input  logic [1:0]        i_rnw,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic [1:0]        o_gnt,
   output logic [1:0]        o_done,
   output logic [1:0]        o_err,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_timeout,
   output logic              o_cs,
   output logic              o_r_neg_w,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   input  logic              i_ack,
   input  logic              i_error,
   input  logic [DATA_W-1:0] i_rdata
);

   // TIMEOUT_CYC is at most 255, so an 8-bit up-counter covers it.
   localparam int              CNT_W  = 8;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              ptr, ptr_nx;
   logic              gnt_idx, gnt_idx_nx;

   logic [1:0]        gnt_nx, done_nx, err_nx;
   logic [DATA_W-1:0] rdata_nx, wdata_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic              timeout_nx, cs_nx, rnw_nx;

   logic              arb_valid, arb_idx;

   can_rr_arb2 u_arb (
      .req   (i_req),
      .ptr   (ptr),
      .valid (arb_valid),
      .idx   (arb_idx)
   );

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      ptr_nx     = ptr;
      gnt_idx_nx = gnt_idx;
      gnt_nx     = o_gnt;
      done_nx    = 2'b00;
      err_nx     = 2'b00;
      timeout_nx = 1'b0;
      rdata_nx   = o_rdata;
      cs_nx      = o_cs;
      rnw_nx     = o_r_neg_w;
      addr_nx    = o_addr;
      wdata_nx   = o_wdata;

      case (state)
         IDLE: begin
            if (arb_valid) begin
               gnt_idx_nx = arb_idx;
               gnt_nx     = onehot2(arb_idx);
               cs_nx      = 1'b1;
               rnw_nx     = i_rnw[arb_idx];
               addr_nx    = (arb_idx == REQ_ENGINE) ? i_addr1  : i_addr0;
               wdata_nx   = (arb_idx == REQ_ENGINE) ? i_wdata1 : i_wdata0;
               cnt_nx     = '0;
               state_nx   = WAIT;
            end
         end

         WAIT: begin
            // Ack is checked first so it wins over a coincident terminal count.
            if (i_ack) begin
               if (o_r_neg_w) begin
                  rdata_nx = i_rdata;
               end
               done_nx  = onehot2(gnt_idx);
               err_nx   = i_error ? onehot2(gnt_idx) : 2'b00;
               cs_nx    = 1'b0;
               gnt_nx   = 2'b00;
               ptr_nx   = ~ptr;
               state_nx = GAP;
            end else if (cnt == CNT_TC) begin
               done_nx    = onehot2(gnt_idx);
               err_nx     = onehot2(gnt_idx);
               timeout_nx = 1'b1;
               cs_nx      = 1'b0;
               gnt_nx     = 2'b00;
               ptr_nx     = ~ptr;
               state_nx   = GAP;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end

         GAP: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end

         default: begin
            cs_nx    = 1'b0;
            gnt_nx   = 2'b00;
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ptr       <= REQ_HOST;
         gnt_idx   <= REQ_HOST;
         o_gnt     <= 2'b00;
         o_done    <= 2'b00;
         o_err     <= 2'b00;
         o_rdata   <= '0;
         o_timeout <= 1'b0;
         o_cs      <= 1'b0;
         o_r_neg_w <= 1'b0;
         o_addr    <= '0;
         o_wdata   <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         ptr       <= ptr_nx;
         gnt_idx   <= gnt_idx_nx;
         o_gnt     <= gnt_nx;
         o_done    <= done_nx;
         o_err     <= err_nx;
         o_rdata   <= rdata_nx;
         o_timeout <= timeout_nx;
         o_cs      <= cs_nx;
         o_r_neg_w <= rnw_nx;
         o_addr    <= addr_nx;
         o_wdata   <= wdata_nx;
      end
   end

   a_gnt_onehot : assert property (@(posedge i_sys_clk) disable iff (i_reset)
      $onehot0(o_gnt));
   a_cs_in_wait : assert property (@(posedge i_sys_clk) disable iff (i_reset)
      o_cs == (state == WAIT));
   a_timeout_done : assert property (@(posedge i_sys_clk) disable iff (i_reset)
      o_timeout |-> (o_done != 2'b00));

endmodule

// File: tb/tb_can_mc_arbiter.sv
module tb_can_mc_arbiter;
   import can_mc_pkg::*;

   localparam int TO = 16;

   logic              i_sys_clk = 1'b0;
   logic              i_reset   = 1'b1;
   logic [1:0]        i_req     = 2'b00;
   logic [1:0]        i_rnw     = 2'b00;
   logic [5:0]        i_addr0   = '0;
   logic [5:0]        i_addr1   = '0;
   logic [31:0]       i_wdata0  = '0;
   logic [31:0]       i_wdata1  = '0;
   logic              i_ack     = 1'b0;
   logic              i_error   = 1'b0;
   logic [31:0]       i_rdata   = '0;
   logic [1:0]        o_gnt, o_done, o_err;
   logic [31:0]       o_rdata, o_wdata;
   logic              o_timeout, o_cs, o_r_neg_w;
   logic [5:0]        o_addr;

   int checks   = 0;
   int failures = 0;

   // Reference model state: tie-break pointer and last read data.
   int          m_ptr   = 0;
   logic [31:0] m_rdata = '0;

   always #5 i_sys_clk = ~i_sys_clk;

   can_mc_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .i_sys_clk (i_sys_clk),
      .i_reset   (i_reset),
      .i_req     (i_req),
      .i_rnw     (i_rnw),
      .i_addr0   (i_addr0),
      .i_addr1   (i_addr1),
      .i_wdata0  (i_wdata0),
      .i_wdata1  (i_wdata1),
      .o_gnt     (o_gnt),
      .o_done    (o_done),
      .o_err     (o_err),
      .o_rdata   (o_rdata),
      .o_timeout (o_timeout),
      .o_cs      (o_cs),
      .o_r_neg_w (o_r_neg_w),
      .o_addr    (o_addr),
      .o_wdata   (o_wdata),
      .i_ack     (i_ack),
      .i_error   (i_error),
      .i_rdata   (i_rdata)
   );

   task automatic step();
      @(posedge i_sys_clk);
      #1;
   endtask

   task automatic apply_reset();
      i_reset = 1'b1;
      i_req   = 2'b00;
      i_ack   = 1'b0;
      i_error = 1'b0;
      step();
      step();
      i_reset = 1'b0;
      step();
      m_ptr   = 0;
      m_rdata = '0;
   endtask

   // One complete transaction. ack_cyc is the WAIT cycle (1-based) on which
   // the slave acks; 0 or anything beyond TO means the slave never acks.
   task automatic do_txn(input string name, input logic [1:0] req_v,
                         input int ack_cyc, input logic ack_err,
                         input logic [31:0] ack_data, input bit drop_mid,
                         input bit keep_req);
      int          win, n, exp_n;
      bit          seen, exp_to;
      logic [1:0]  exp_oh, exp_err;
      logic [5:0]  exp_addr;
      logic [31:0] exp_wdata, exp_rd;
      logic        exp_rnw;

      i_req     = req_v;
      win       = req_v[m_ptr] ? m_ptr : 1 - m_ptr;
      exp_oh    = (win == 1) ? 2'b10 : 2'b01;
      exp_addr  = (win == 1) ? i_addr1 : i_addr0;
      exp_wdata = (win == 1) ? i_wdata1 : i_wdata0;
      exp_rnw   = i_rnw[win];
      exp_to    = !(ack_cyc >= 1 && ack_cyc <= TO);
      exp_n     = exp_to ? TO : ack_cyc;

      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (o_cs === 1'b1) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s cs_start: o_cs=%b never rose, required 1", name, o_cs);
         i_req = 2'b00;
         return;
      end
      checks++;
      if (o_gnt !== exp_oh) begin
         failures++;
         $display("FAIL %s gnt: got %b required %b", name, o_gnt, exp_oh);
      end
      checks++;
      if ({o_r_neg_w, o_addr, o_wdata} !== {exp_rnw, exp_addr, exp_wdata}) begin
         failures++;
         $display("FAIL %s cmd: got rnw=%b addr=%h wdata=%h required rnw=%b addr=%h wdata=%h",
                  name, o_r_neg_w, o_addr, o_wdata, exp_rnw, exp_addr, exp_wdata);
      end

      n = 0;
      for (int c = 1; c <= TO + 2; c++) begin
         n = c;
         if (c == ack_cyc) begin
            i_ack   = 1'b1;
            i_error = ack_err;
            i_rdata = ack_data;
         end else begin
            i_ack   = 1'b0;
            i_error = 1'($urandom);
            i_rdata = $urandom;
         end
         if (drop_mid && c == 2) i_req[win] = 1'b0;
         step();
         i_ack = 1'b0;
         if (o_done !== 2'b00) break;
         checks++;
         if (o_cs !== 1'b1 || o_addr !== exp_addr || o_gnt !== exp_oh) begin
            failures++;
            $display("FAIL %s wait_stable c=%0d: cs=%b addr=%h gnt=%b required cs=1 addr=%h gnt=%b",
                     name, c, o_cs, o_addr, o_gnt, exp_addr, exp_oh);
         end
      end

      exp_rd  = (!exp_to && exp_rnw) ? ack_data : m_rdata;
      exp_err = (exp_to || ack_err) ? exp_oh : 2'b00;
      checks++;
      if (n != exp_n) begin
         failures++;
         $display("FAIL %s wait_len: got %0d cycles required %0d", name, n, exp_n);
      end
      checks++;
      if (o_done !== exp_oh || o_err !== exp_err || o_timeout !== exp_to) begin
         failures++;
         $display("FAIL %s done: got done=%b err=%b to=%b required done=%b err=%b to=%b",
                  name, o_done, o_err, o_timeout, exp_oh, exp_err, exp_to);
      end
      checks++;
      if (o_rdata !== exp_rd) begin
         failures++;
         $display("FAIL %s rdata: got %h required %h", name, o_rdata, exp_rd);
      end
      checks++;
      if (o_gnt !== 2'b00 || o_cs !== 1'b0) begin
         failures++;
         $display("FAIL %s gap: got gnt=%b cs=%b required 00/0", name, o_gnt, o_cs);
      end
      m_rdata = exp_rd;
      m_ptr   = 1 - m_ptr;
      if (!keep_req) i_req[win] = 1'b0;

      // Ack during GAP must be ignored.
      i_ack   = 1'b1;
      i_error = 1'b1;
      i_rdata = $urandom;
      step();
      i_ack   = 1'b0;
      i_error = 1'b0;
      checks++;
      if (o_done !== 2'b00 || o_timeout !== 1'b0 || o_cs !== 1'b0 || o_rdata !== m_rdata) begin
         failures++;
         $display("FAIL %s after_gap: got done=%b to=%b cs=%b rdata=%h required 00/0/0/%h",
                  name, o_done, o_timeout, o_cs, o_rdata, m_rdata);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({o_gnt, o_done, o_err, o_timeout, o_cs, o_r_neg_w} !== 9'd0 ||
          o_rdata !== 32'd0 || o_addr !== 6'd0 || o_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: gnt=%b done=%b err=%b to=%b cs=%b rnw=%b addr=%h rdata=%h wdata=%h required all 0",
                  o_gnt, o_done, o_err, o_timeout, o_cs, o_r_neg_w, o_addr, o_rdata, o_wdata);
      end
   endtask

   task automatic test_host_read();
      apply_reset();
      i_rnw   = 2'b01;
      i_addr0 = 6'h05;
      do_txn("host_read", 2'b01, 3, 1'b0, 32'hDEADBEEF, 0, 0);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      i_rnw    = 2'b00;
      i_addr0  = 6'h01;
      i_wdata0 = 32'h11111111;
      i_addr1  = 6'h02;
      i_wdata1 = 32'h22222222;
      do_txn("b2b_1", 2'b11, 2, 1'b0, 32'h0, 0, 1);
      do_txn("b2b_2", 2'b11, 1, 1'b0, 32'h0, 0, 1);
      do_txn("b2b_3", 2'b11, 4, 1'b0, 32'h0, 0, 0);
      i_req = 2'b00;
   endtask

   task automatic test_timeout();
      apply_reset();
      i_rnw    = 2'b00;
      i_addr1  = 6'h3A;
      i_wdata1 = 32'hCAFE0001;
      do_txn("eng_timeout", 2'b10, 0, 1'b0, 32'h0, 0, 0);
   endtask

   task automatic test_ack_at_tc();
      apply_reset();
      i_rnw   = 2'b01;
      i_addr0 = 6'h10;
      do_txn("ack_at_tc", 2'b01, TO, 1'b1, 32'h0BADF00D, 0, 0);
   endtask

   task automatic test_drop_req();
      apply_reset();
      i_rnw   = 2'b10;
      i_addr1 = 6'h22;
      do_txn("drop_mid", 2'b10, 5, 1'b0, 32'h12345678, 1, 0);
   endtask

   task automatic test_reset_mid_wait();
      bit seen;
      apply_reset();
      i_rnw   = 2'b00;
      i_addr0 = 6'h07;
      i_req   = 2'b01;
      seen    = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (o_cs === 1'b1) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rst_mid cs_start: o_cs=%b never rose, required 1", o_cs);
      end
      step();
      #2;
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_cs !== 1'b0 || o_gnt !== 2'b00 || o_done !== 2'b00) begin
         failures++;
         $display("FAIL rst_mid async: cs=%b gnt=%b done=%b required 0/00/00", o_cs, o_gnt, o_done);
      end
      i_req = 2'b00;
      step();
      i_reset = 1'b0;
      m_ptr   = 0;
      m_rdata = '0;
      step();
      checks++;
      if (o_done !== 2'b00 || o_cs !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid no_done: done=%b cs=%b required 00/0", o_done, o_cs);
      end
      i_rnw    = 2'b00;
      i_addr1  = 6'h2B;
      i_wdata1 = 32'hA5A5A5A5;
      do_txn("rst_then_eng", 2'b10, 2, 1'b0, 32'h0, 0, 0);
   endtask

   task automatic test_random();
      apply_reset();
      for (int t = 0; t < 40; t++) begin
         logic [1:0] rq;
         rq       = 2'($urandom_range(1, 3));
         i_rnw    = 2'($urandom);
         i_addr0  = 6'($urandom);
         i_addr1  = 6'($urandom);
         i_wdata0 = $urandom;
         i_wdata1 = $urandom;
         do_txn("random", rq, $urandom_range(0, 20), 1'($urandom), $urandom,
                bit'($urandom_range(0, 3) == 0), 0);
      end
      i_req = 2'b00;
   endtask

   initial begin
      test_reset();
      test_host_read();
      test_back_to_back();
      test_timeout();
      test_ack_at_tc();
      test_drop_req();
      test_reset_mid_wait();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/can_mc_arbiter.md
CAN_MC_ARBITER -- requirements
Module: can_mc_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum WAIT-state cycles before a transaction is aborted (legal range 2..255).
REQ-002 The block SHALL have port i_sys_clk, input, 1, 100 MHz system clock.
REQ-003 The block SHALL have port i_reset, input, 1, reset (asynchronous, active-high).
REQ-004 The block SHALL have port i_req, input, [1:0], per-requester request (bit0 host, bit1 internal engine), level, held until o_done.
REQ-005 The block SHALL have port i_rnw, input, [1:0], per-requester read (1) or write (0).
REQ-006 The block SHALL have ports i_addr0 and i_addr1, input, [5:0] each, per-requester register address.
REQ-007 The block SHALL have ports i_wdata0 and i_wdata1, input, [31:0] each, per-requester write data.
REQ-008 The block SHALL have port o_gnt, output, [1:0], one-hot grant, high from latch through completion.
REQ-009 The block SHALL have port o_done, output, [1:0], one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have port o_err, output, [1:0], qualified by o_done: slave error or timeout.
REQ-011 The block SHALL have port o_rdata, output, [31:0], read data, valid with o_done.
REQ-012 The block SHALL have port o_timeout, output, 1, one-cycle pulse on timeout abort.
REQ-013 The block SHALL have ports o_cs, o_r_neg_w, o_addr[5:0] and o_wdata[31:0], outputs toward the MC interface.
REQ-014 The block SHALL have ports i_ack, i_error and i_rdata[31:0], inputs from the MC interface.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and GAP.
REQ-016 In IDLE with any i_req bit high, the block SHALL pick the winner round-robin, latch its rnw/addr/wdata into the output registers, set o_gnt, and enter WAIT on the next edge.
REQ-017 Round-robin: the pointer SHALL start at requester 0, the pointed requester SHALL win ties, and the pointer SHALL move to the other requester after every completion, including errors and timeouts.
REQ-018 In WAIT, o_cs SHALL be high, o_addr/o_wdata/o_r_neg_w SHALL be stable, and a timeout counter SHALL increment each cycle from 0.
REQ-019 In WAIT, on i_ack the block SHALL register o_rdata=i_rdata (reads only; writes leave o_rdata unchanged), pulse o_done[g], set o_err[g]=i_error, and go to GAP.
REQ-020 In WAIT, on counter==TIMEOUT_CYC-1 without i_ack, the block SHALL pulse o_done[g], o_err[g] and o_timeout, and go to GAP.
REQ-021 When i_ack and the timeout terminal count coincide, ack SHALL win and o_timeout SHALL stay low.
REQ-022 In GAP (exactly 1 cycle), o_cs and o_gnt SHALL be low and the counter SHALL clear; the FSM SHALL then go to IDLE.
REQ-023 Minimum transaction spacing SHALL be 3 cycles, with o_cs low for at least 1 cycle between transactions so the MC interface re-decodes.
REQ-024 A requester dropping i_req mid-transaction SHALL NOT abort it; the transaction SHALL complete normally.
REQ-025 Outside WAIT, i_ack and i_error SHALL be ignored.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On i_reset, the block SHALL asynchronously clear all outputs and the counter to 0, set the state to IDLE and the pointer to requester 0, including mid-transaction, with no o_done pulse.

Structure
REQ-028 A shared package can_mc_pkg SHALL hold the state enum, the ADDR_W=6 and DATA_W=32 constants, and the requester index constants.
REQ-029 One sub-module, can_rr_arb2 (combinational 2-way round-robin pick from request plus pointer), SHALL be used.

Verification
REQ-030 Host read addr 0x05; slave acks on the 3rd WAIT cycle with 0xDEADBEEF -> o_done=01, o_err=0, o_rdata=0xDEADBEEF.
REQ-031 Both request writes (0x01/0x11111111, 0x02/0x22222222) held continuously -> grants alternate 01,10,01; o_cs low 1 cycle between transactions.
REQ-032 Engine write, no ack -> o_done=10, o_err=10 and o_timeout after exactly 16 WAIT cycles.
REQ-033 Ack with i_error=1 on the same cycle as timeout terminal count -> o_err set, o_timeout=0.
REQ-034 i_reset pulsed during WAIT -> o_cs=0, o_gnt=00, no o_done; the next request from requester 1 alone is granted normally.
